// File: rtl/fbfly_link_pipe_array.sv
//------------------------------------------------------------------------------
// Module   : fbfly_link_pipe_array
// Purpose  : Retimed flattened-butterfly links (flit and credit pipes) with
//            upstream credit tracking. Optional macro FBFLY_LINK_PIPE_STATS_EN
//            adds per-link flit_count outputs.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fbfly_link_pipe_array #(
    parameter int NUM_LINKS       = 3,
    parameter int NUM_VCS         = 2,
    parameter int VC_IDX_WIDTH    = 1,
    parameter int FLIT_DATA_WIDTH = 64,
    parameter int CHANNEL_WIDTH   = 1 + VC_IDX_WIDTH + 1 + 1 + FLIT_DATA_WIDTH,
    parameter int FLOW_CTRL_WIDTH = 1 + VC_IDX_WIDTH,
    parameter int FWD_STAGES      = 2,
    parameter int BWD_STAGES      = 2,
    parameter int BUFFER_SIZE     = 8
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [NUM_LINKS*CHANNEL_WIDTH-1:0]   channel_in,
    output logic [NUM_LINKS*CHANNEL_WIDTH-1:0]   channel_out,
    input  logic [NUM_LINKS*FLOW_CTRL_WIDTH-1:0] flow_ctrl_in,
    output logic [NUM_LINKS*FLOW_CTRL_WIDTH-1:0] flow_ctrl_out,
    output logic [NUM_LINKS-1:0]                 error,
`ifdef FBFLY_LINK_PIPE_STATS_EN
    output logic [NUM_LINKS*32-1:0]              flit_count,
`endif
    output logic                                 idle
);

    localparam int CNT_W  = $clog2(BUFFER_SIZE + 1);
    localparam int CH_TOT = NUM_LINKS * CHANNEL_WIDTH;
    localparam int FC_TOT = NUM_LINKS * FLOW_CTRL_WIDTH;

    logic fwd_busy_d;
    logic bwd_busy_d;

    // Forward flit pipe
    if (FWD_STAGES == 0) begin : g_fwd_bypass
        assign channel_out = channel_in;
        assign fwd_busy_d  = 1'b0;
    end else begin : g_fwd_pipe
        logic [CH_TOT-1:0] stage_q [FWD_STAGES];
        logic [CH_TOT-1:0] stage_d [FWD_STAGES];

        always_comb begin
            stage_d[0] = channel_in;
            for (int s = 1; s < FWD_STAGES; s++) begin
                stage_d[s] = stage_q[s-1];
            end
            fwd_busy_d = 1'b0;
            for (int s = 0; s < FWD_STAGES; s++) begin
                for (int l = 0; l < NUM_LINKS; l++) begin
                    fwd_busy_d = fwd_busy_d | stage_d[s][l*CHANNEL_WIDTH + CHANNEL_WIDTH - 1];
                end
            end
        end

        always_ff @(posedge clk) begin
            for (int s = 0; s < FWD_STAGES; s++) begin
                if (!reset) stage_q[s] <= '0;
                else        stage_q[s] <= stage_d[s];
            end
        end

        assign channel_out = stage_q[FWD_STAGES-1];
    end

    // Reverse credit pipe
    if (BWD_STAGES == 0) begin : g_bwd_bypass
        assign flow_ctrl_out = flow_ctrl_in;
        assign bwd_busy_d    = 1'b0;
    end else begin : g_bwd_pipe
        logic [FC_TOT-1:0] stage_q [BWD_STAGES];
        logic [FC_TOT-1:0] stage_d [BWD_STAGES];

        always_comb begin
            stage_d[0] = flow_ctrl_in;
            for (int s = 1; s < BWD_STAGES; s++) begin
                stage_d[s] = stage_q[s-1];
            end
            bwd_busy_d = 1'b0;
            for (int s = 0; s < BWD_STAGES; s++) begin
                for (int l = 0; l < NUM_LINKS; l++) begin
                    bwd_busy_d = bwd_busy_d | stage_d[s][l*FLOW_CTRL_WIDTH + FLOW_CTRL_WIDTH - 1];
                end
            end
        end

        always_ff @(posedge clk) begin
            for (int s = 0; s < BWD_STAGES; s++) begin
                if (!reset) stage_q[s] <= '0;
                else        stage_q[s] <= stage_d[s];
            end
        end

        assign flow_ctrl_out = stage_q[BWD_STAGES-1];
    end

    // Per-link field decode: valid is the MSB, VC index sits just below it
    logic [NUM_LINKS-1:0]                   ch_valid;
    logic [NUM_LINKS-1:0]                   fc_valid;
    logic [NUM_LINKS-1:0][VC_IDX_WIDTH-1:0] ch_vc;
    logic [NUM_LINKS-1:0][VC_IDX_WIDTH-1:0] fc_vc;
    logic [NUM_LINKS-1:0]                   ch_bad;
    logic [NUM_LINKS-1:0]                   fc_bad;

    for (genvar l = 0; l < NUM_LINKS; l++) begin : g_link_decode
        assign ch_valid[l] = channel_in[l*CHANNEL_WIDTH + CHANNEL_WIDTH - 1];
        assign ch_vc[l]    = channel_in[l*CHANNEL_WIDTH + CHANNEL_WIDTH - 2 -: VC_IDX_WIDTH];
        assign fc_valid[l] = flow_ctrl_out[l*FLOW_CTRL_WIDTH + FLOW_CTRL_WIDTH - 1];
        assign fc_vc[l]    = flow_ctrl_out[l*FLOW_CTRL_WIDTH + FLOW_CTRL_WIDTH - 2 -: VC_IDX_WIDTH];

        // Out-of-range indices only exist when NUM_VCS is not a power of two
        if (NUM_VCS < (1 << VC_IDX_WIDTH)) begin : g_vc_range_chk
            assign ch_bad[l] = (ch_vc[l] >= VC_IDX_WIDTH'(NUM_VCS));
            assign fc_bad[l] = (fc_vc[l] >= VC_IDX_WIDTH'(NUM_VCS));
        end else begin : g_vc_range_full
            assign ch_bad[l] = 1'b0;
            assign fc_bad[l] = 1'b0;
        end
    end

    logic [NUM_LINKS-1:0][NUM_VCS-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [NUM_LINKS-1:0]                         error_q, error_d;
    logic                                         idle_q, idle_d;

    always_comb begin
        logic inc;
        logic dec;
        inc     = 1'b0;
        dec     = 1'b0;
        cnt_d   = cnt_q;
        error_d = error_q;
        for (int l = 0; l < NUM_LINKS; l++) begin
            if ((ch_valid[l] && ch_bad[l]) || (fc_valid[l] && fc_bad[l])) begin
                error_d[l] = 1'b1;
            end
            for (int v = 0; v < NUM_VCS; v++) begin
                inc = ch_valid[l] && !ch_bad[l] && (ch_vc[l] == VC_IDX_WIDTH'(v));
                dec = fc_valid[l] && !fc_bad[l] && (fc_vc[l] == VC_IDX_WIDTH'(v));
                if (inc && !dec) begin
                    if (cnt_q[l][v] == CNT_W'(BUFFER_SIZE)) error_d[l] = 1'b1;
                    else                                    cnt_d[l][v] = cnt_q[l][v] + CNT_W'(1);
                end else if (dec && !inc) begin
                    if (cnt_q[l][v] == '0) error_d[l] = 1'b1;
                    else                   cnt_d[l][v] = cnt_q[l][v] - CNT_W'(1);
                end
            end
        end
        idle_d = !fwd_busy_d && !bwd_busy_d && (cnt_d == '0);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q   <= '0;
            error_q <= '0;
            idle_q  <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            error_q <= error_d;
            idle_q  <= idle_d;
        end
    end

    assign error = error_q;
    assign idle  = idle_q;

`ifdef FBFLY_LINK_PIPE_STATS_EN
    logic [NUM_LINKS-1:0][31:0] flit_count_q, flit_count_d;

    always_comb begin
        flit_count_d = flit_count_q;
        for (int l = 0; l < NUM_LINKS; l++) begin
            flit_count_d[l] = flit_count_q[l]
                            + 32'(channel_out[l*CHANNEL_WIDTH + CHANNEL_WIDTH - 1]);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) flit_count_q <= '0;
        else        flit_count_q <= flit_count_d;
    end

    assign flit_count = flit_count_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fbfly_link_pipe_array.sv
//------------------------------------------------------------------------------
// Module   : tb_fbfly_link_pipe_array
// Purpose  : Directed bench: pipelined instance (2 fwd / 3 bwd) and a
//            passthrough instance driven from a vector table.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_fbfly_link_pipe_array;

    localparam int NL  = 3;
    localparam int VCW = 1;
    localparam int DW  = 64;
    localparam int CW  = 1 + VCW + 1 + 1 + DW;
    localparam int FW  = 1 + VCW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset;
    logic [NL*CW-1:0]  a_ch_in, a_ch_out, b_ch_in, b_ch_out;
    logic [NL*FW-1:0]  a_fc_in, a_fc_out, b_fc_in, b_fc_out;
    logic [NL-1:0]     a_err, b_err;
    logic              a_idle, b_idle;
`ifdef FBFLY_LINK_PIPE_STATS_EN
    logic [NL*32-1:0]  a_flit_count, b_flit_count;
`endif

    fbfly_link_pipe_array #(.FWD_STAGES(2), .BWD_STAGES(3)) u_dut_a (
        .clk           (clk),
        .reset         (reset),
        .channel_in    (a_ch_in),
        .channel_out   (a_ch_out),
        .flow_ctrl_in  (a_fc_in),
        .flow_ctrl_out (a_fc_out),
        .error         (a_err),
`ifdef FBFLY_LINK_PIPE_STATS_EN
        .flit_count    (a_flit_count),
`endif
        .idle          (a_idle)
    );

    fbfly_link_pipe_array #(.FWD_STAGES(0), .BWD_STAGES(0)) u_dut_b (
        .clk           (clk),
        .reset         (reset),
        .channel_in    (b_ch_in),
        .channel_out   (b_ch_out),
        .flow_ctrl_in  (b_fc_in),
        .flow_ctrl_out (b_fc_out),
        .error         (b_err),
`ifdef FBFLY_LINK_PIPE_STATS_EN
        .flit_count    (b_flit_count),
`endif
        .idle          (b_idle)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        a_ch_in = '0; a_fc_in = '0; b_ch_in = '0; b_fc_in = '0;
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
    endtask

    function automatic logic [CW-1:0] mk_ch(input logic [VCW-1:0] vc, input logic [DW-1:0] d);
        return {1'b1, vc, 1'b1, 1'b1, d};
    endfunction

    function automatic logic [FW-1:0] mk_fc(input logic [VCW-1:0] vc);
        return {1'b1, vc};
    endfunction

    typedef struct {
        logic [CW-1:0] ch;
        logic [FW-1:0] fc;
        logic [NL-1:0] err;
        logic          idle;
    } vec_t;

    vec_t tbl [9];

    initial begin
        logic [CW-1:0] flit;
        logic [FW-1:0] cred;

        tbl[0] = '{mk_ch(1'b0, 64'd1), 2'b00,       3'b000, 1'b0};
        tbl[1] = '{mk_ch(1'b0, 64'd2), 2'b00,       3'b000, 1'b0};
        tbl[2] = '{mk_ch(1'b1, 64'd3), mk_fc(1'b0), 3'b000, 1'b0};
        tbl[3] = '{mk_ch(1'b0, 64'd4), mk_fc(1'b0), 3'b000, 1'b0};
        tbl[4] = '{'0,                 mk_fc(1'b0), 3'b000, 1'b0};
        tbl[5] = '{'0,                 mk_fc(1'b1), 3'b000, 1'b1};
        tbl[6] = '{'0,                 2'b00,       3'b000, 1'b1};
        tbl[7] = '{'0,                 mk_fc(1'b1), 3'b001, 1'b1};
        tbl[8] = '{mk_ch(1'b1, 64'd9), 2'b00,       3'b001, 1'b0};

        do_reset();
        chk("rst_a_chout", 256'(a_ch_out), 256'd0);
        chk("rst_a_fcout", 256'(a_fc_out), 256'd0);
        chk("rst_a_err",   256'(a_err),    256'd0);
        chk("rst_a_idle",  256'(a_idle),   256'd1);
        chk("rst_b_idle",  256'(b_idle),   256'd1);

        // Latency: flit appears two edges after capture, credit three
        flit = mk_ch(1'b1, 64'hA5);
        a_ch_in[0 +: CW] = flit;
        step();
        a_ch_in = '0;
        chk("lat_ch_e1",   256'(a_ch_out[0 +: CW]), 256'd0);
        chk("lat_idle_e1", 256'(a_idle), 256'd0);
        step();
        chk("lat_ch_e2", 256'(a_ch_out[0 +: CW]), 256'(flit));
        step();
        chk("lat_ch_e3", 256'(a_ch_out), 256'd0);
        cred = mk_fc(1'b1);
        a_fc_in[0 +: FW] = cred;
        step();
        a_fc_in = '0;
        chk("lat_fc_e1", 256'(a_fc_out), 256'd0);
        step();
        chk("lat_fc_e2", 256'(a_fc_out), 256'd0);
        step();
        chk("lat_fc_e3",   256'(a_fc_out[0 +: FW]), 256'(cred));
        chk("lat_idle_e3", 256'(a_idle), 256'd0);
        step();
        chk("lat_idle_e4", 256'(a_idle), 256'd1);
        chk("lat_err",     256'(a_err),  256'd0);

        // Underflow on link 2
        a_fc_in[2*FW +: FW] = mk_fc(1'b1);
        step();
        a_fc_in = '0;
        step();
        step();
        chk("unf_err_e3", 256'(a_err), 256'd0);
        step();
        chk("unf_err_e4",  256'(a_err),  256'b100);
        chk("unf_idle_e4", 256'(a_idle), 256'd1);

        // Simultaneous inc/dec on link 0 VC0 with count 3
        do_reset();
        a_ch_in[0 +: CW] = mk_ch(1'b0, 64'd0);
        repeat (3) step();
        a_ch_in = '0;
        a_fc_in[0 +: FW] = mk_fc(1'b0);
        step();
        a_fc_in = '0;
        step();
        step();
        a_ch_in[0 +: CW] = mk_ch(1'b0, 64'd7);
        step();
        a_ch_in = '0;
        chk("sim_err", 256'(a_err), 256'd0);
        a_fc_in[0 +: FW] = mk_fc(1'b0);
        repeat (3) step();
        a_fc_in = '0;
        repeat (4) step();
        chk("sim_drain_idle", 256'(a_idle), 256'd1);
        chk("sim_drain_err",  256'(a_err),  256'd0);

        // Mixed VCs: VC0 +1 while VC1 -1 in the same cycle
        do_reset();
        a_ch_in[0 +: CW] = mk_ch(1'b1, 64'd0);
        a_fc_in[0 +: FW] = mk_fc(1'b1);
        step();
        a_ch_in = '0;
        a_fc_in = '0;
        step();
        step();
        a_ch_in[0 +: CW] = mk_ch(1'b0, 64'd1);
        step();
        a_ch_in = '0;
        chk("mix_err",  256'(a_err),  256'd0);
        chk("mix_idle", 256'(a_idle), 256'd0);
        a_fc_in[0 +: FW] = mk_fc(1'b0);
        step();
        a_fc_in = '0;
        repeat (4) step();
        chk("mix_drain_idle", 256'(a_idle), 256'd1);
        chk("mix_drain_err",  256'(a_err),  256'd0);

        // Overflow on link 1 VC0: ninth flit trips the error
        do_reset();
        a_ch_in[1*CW +: CW] = mk_ch(1'b0, 64'h55);
        repeat (8) step();
        chk("ovf_err_8", 256'(a_err), 256'd0);
        step();
        a_ch_in = '0;
        chk("ovf_err_9", 256'(a_err), 256'b010);
        a_fc_in[1*FW +: FW] = mk_fc(1'b0);
        repeat (8) step();
        a_fc_in = '0;
        repeat (5) step();
        chk("ovf_sat_idle", 256'(a_idle), 256'd1);
        chk("ovf_sticky",   256'(a_err),  256'b010);

        // Reset mid-operation with every stage loaded
        for (int l = 0; l < NL; l++) begin
            a_ch_in[l*CW +: CW] = mk_ch(1'b1, 64'(l + 16));
            a_fc_in[l*FW +: FW] = mk_fc(1'b0);
        end
        repeat (3) step();
        a_ch_in = '0;
        a_fc_in = '0;
        reset = 1'b0;
        step();
        reset = 1'b1;
        chk("mrst_chout", 256'(a_ch_out), 256'd0);
        chk("mrst_fcout", 256'(a_fc_out), 256'd0);
        chk("mrst_err",   256'(a_err),    256'd0);
        chk("mrst_idle",  256'(a_idle),   256'd1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("mrst_flush_ch", 256'(a_ch_out), 256'd0);
            chk("mrst_flush_fc", 256'(a_fc_out), 256'd0);
        end
        chk("mrst_idle_after", 256'(a_idle), 256'd1);

        // Passthrough instance, table-driven on link 0
        do_reset();
        for (int i = 0; i < 9; i++) begin
            b_ch_in[0 +: CW] = tbl[i].ch;
            b_fc_in[0 +: FW] = tbl[i].fc;
            #1;
            chk("pt_chout", 256'(b_ch_out), 256'(tbl[i].ch));
            chk("pt_fcout", 256'(b_fc_out), 256'(tbl[i].fc));
            step();
            chk("pt_err",  256'(b_err),  256'(tbl[i].err));
            chk("pt_idle", 256'(b_idle), 256'(tbl[i].idle));
        end
        b_ch_in = '0;
        b_fc_in = '0;
`ifdef FBFLY_LINK_PIPE_STATS_EN
        step();
        chk("stats_link0", 256'(b_flit_count[0 +: 32]),  256'd5);
        chk("stats_link1", 256'(b_flit_count[32 +: 32]), 256'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fbfly_link_pipe_array.md
Name: fbfly_link_pipe_array

Overview:
- Parametrised array of retimed inter-router links for the flattened-butterfly interconnect.
- Inserts a configurable number of register stages on each forward flit channel and each reverse flow-control (credit) channel, so long fbfly links can close timing.
- Tracks outstanding credits per link per VC at the upstream boundary and flags protocol violations.
- Instanced between router_wrap output ports and neighbour input ports; one instance carries all links of a dimension.

Parameters:
- num_links, 3, number of independent links carried (e.g. num_routers_per_dim-1).
- num_vcs, 2, VCs per link.
- vc_idx_width, 1, clogb(num_vcs).
- flit_data_width, 64, flit payload bits.
- channel_width, 1+vc_idx_width+1+1+flit_data_width, per-link channel bits (head/tail format, no link PM).
- flow_ctrl_width, 1+vc_idx_width, per-link credit bits.
- fwd_stages, 2, forward register stages (0..8); 0 = combinational passthrough.
- bwd_stages, 2, credit return register stages (0..8); 0 = passthrough.
- buffer_size, 8, downstream buffer depth in flits per VC (the credit ceiling).

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-low reset (reset==0 resets on the rising edge of clk).
- channel_in  input  num_links*channel_width  flits from upstream router output ports, link i at [i*channel_width +: channel_width].
- channel_out  output  num_links*channel_width  flits to downstream router input ports.
- flow_ctrl_in  input  num_links*flow_ctrl_width  credits from downstream router.
- flow_ctrl_out  output  num_links*flow_ctrl_width  credits to upstream router.
- error  output  num_links  sticky per-link credit protocol error.
- idle  output  1  all pipes empty and all outstanding counters zero.

Behaviour:
- Field layout, per link, MSB-first [0:...] indexing:
  - channel bit 0 = flit valid; bits 1..vc_idx_width = VC index.
  - flow_ctrl bit 0 = credit valid; bits 1..vc_idx_width = VC index.
- Forward path:
  - channel_out equals channel_in delayed exactly fwd_stages cycles; every bit, including data, is registered.
  - One flit per link per cycle; no stalls and no backpressure.
- Reverse path: flow_ctrl_out equals flow_ctrl_in delayed exactly bwd_stages cycles.
- Reset:
  - All pipeline registers clear to 0, so channel_out=0 and flow_ctrl_out=0 from the first cycle after reset is sampled low and for as long as it stays low.
  - Counters clear to 0, error=0, idle=1.
  - Reset asserted mid-transfer discards in-flight flits and credits; no partial state survives.
- Outstanding counter, one per link per VC, width clogb(buffer_size+1):
  - Increments when channel_in valid is set for that VC.
  - Decrements when flow_ctrl_out valid is set for that VC (credit observed at the upstream end).
  - Increment and decrement on the same VC in the same cycle: counter unchanged, no error.
  - Increment while counter == buffer_size: overflow; counter holds at buffer_size and error[i] sets.
  - Decrement while counter == 0 (no simultaneous increment): underflow; counter holds at 0 and error[i] sets.
  - error[i] is sticky until reset. Asserts the cycle after the offending input.
- idle, registered:
  - 1 when no valid bit is set in any forward or reverse stage, and all counters are 0.
  - Evaluated from the next-state values, so idle drops in the same cycle the first flit enters a stage.
  - With zero stages, only the counters count.
- Out-of-range VC index (>= num_vcs) on an incoming valid: error[i] sets; counters unchanged.

Optional Feature:
- Macro: FBFLY_LINK_PIPE_STATS_EN.
- When defined:
  - Adds output port flit_count (num_links*32 bits).
  - Each link has a 32-bit counter of valid flits leaving channel_out, cleared on reset, wrapping 0xFFFFFFFF→0 without error.
- When undefined: the port and counters are absent, and behaviour is otherwise identical.

Test Plan:
- Latency: fwd_stages=2, bwd_stages=3; flit valid VC1 data 0xA5 on link 0 at cycle 10 → channel_out link 0 shows it at cycle 12. Credit on flow_ctrl_in at cycle 20 → flow_ctrl_out at cycle 23. Counter VC1 goes 0→1→0; error=0.
- Overflow: send 9 flits on link 1 VC0 with no credits, buffer_size=8 → counter saturates at 8; error[1]=1 the cycle after flit 9; other links' error stays 0.
- Underflow: credit VC1 on link 2 with zero outstanding → error[2]=1 one cycle after it appears at flow_ctrl_out; counter stays 0.
- Simultaneous: counter=3 on link 0 VC0; flit VC0 in and credit VC0 out in the same cycle → counter stays 3, no error. Mixed VCs in the same cycle → VC0 +1 and VC1 -1.
- Reset mid-operation: flits in all stages plus error set; drive reset=0 for one cycle → next cycle channel_out=0, flow_ctrl_out=0, error=0, idle=1; earlier in-flight flits never emerge.
- Passthrough with stats: fwd_stages=0, bwd_stages=0, FBFLY_LINK_PIPE_STATS_EN defined → channel_out==channel_in the same cycle; after 5 flits, flit_count link 0 = 5.
